plus_asic_unlock: RTL and testbench
===================================

# plus_asic_unlock

CPC Plus ASIC unlock-sequence detector. It snoops CPU I/O writes to the CRTC register-select port (BCxx) and recognises the 17-byte Plus unlock sequence. It maintains the ASIC lock state that qualifies the Plus-only MRER/RMR2 decoding in the memory-mapping stage and the ASIC register page. It sits directly upstream of the MMU on the same io_WR/A/D bus, and its `asic_unlocked` output gates the MMU's Plus control decoding.

## Interface
- CLK  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; forces the reset state below
- plus_mode  in  1  1 = Plus machine; 0 = classic CPC, detector held in reset state
- io_WR  in  1  CPU I/O write strobe, level; the same signal the MMU sees
- A  in  16  CPU address
- D  in  8  CPU data bus
- asic_unlocked  out  1  1 = ASIC features unlocked; registered
- unlock_now  out  1  one-cycle pulse when a completed sequence ends in EE
- lock_now  out  1  one-cycle pulse when a completed sequence ends in a non-EE byte
- seq_pos  out  5  current sequence index 0..15, for debug/verification

## Operation
- Write event:
  - `wr_ev = ~old_wr & io_WR & (A[15:8]==8'hBC)`, where `old_wr` is io_WR registered one cycle.
  - Only `wr_ev` cycles affect state; all other cycles hold state.
- prev_nz register:
  - On every `wr_ev`, `prev_nz <= (D != 8'h00)`.
- seq_pos states:
  - 0 = hunting.
  - 1..14 = expecting `EXP[seq_pos]`.
  - 15 = expecting the final byte.
- Expected bytes:
  - EXP[1..14] = FF,77,B3,51,A8,D4,62,39,9C,46,2B,15,8A,CD.
  - The full sequence on the bus is nonzero, 00, FF, 77, …, CD, EE.
- Transition on `wr_ev`, evaluated in this order:
  1. Final byte, seq_pos==15:
     - D==EE: `asic_unlocked<=1`, `unlock_now<=1`.
     - Otherwise: `asic_unlocked<=0`, `lock_now<=1`.
  2. Resync, all states including 15: if `D==00 && prev_nz` (prev_nz value before this write), then `seq_pos<=1`.
  3. Otherwise, for seq_pos 1..14:
     - `D==EXP[seq_pos]`: `seq_pos<=seq_pos+1`.
     - Any other byte: `seq_pos<=0`.
  4. Otherwise, for seq_pos 0 or 15: `seq_pos<=0`.
- A mismatch never changes `asic_unlocked`. Only completing a sequence (reaching seq_pos 15 and writing one more byte) changes it.
- Repeating the unlock while already unlocked still pulses `unlock_now`.
- plus_mode==0:
  - Each cycle, seq_pos, prev_nz, asic_unlocked and the pulses are forced to reset values.
  - `old_wr` keeps tracking io_WR.
- Non-BCxx writes (7Fxx, DFxx, etc.) are ignored entirely. They do not break a sequence in progress.

## Timing
- Reset values: asic_unlocked=0, unlock_now=0, lock_now=0, seq_pos=0, prev_nz=0, old_wr=0.
- Reset takes effect on the clock edge where reset=1 and has priority over everything. Reset mid-sequence returns to hunting and relocks.
- Latency:
  - io_WR first sampled high in cycle N with `old_wr==0` means `wr_ev` is in cycle N.
  - seq_pos, asic_unlocked and the pulses update at the end of cycle N and are visible in cycle N+1.
  - This matches the MMU's edge timing, so MMU decoding in cycle N+1 sees the new lock state.
- Pulse width: unlock_now and lock_now are high for exactly one cycle, then self-clear. They are never both high.
- io_WR held high for many cycles produces exactly one `wr_ev`. A new event requires io_WR to go low for at least one cycle.
- `wr_ev` can fire at most every second cycle.

## Test plan
- Full unlock: after reset, BCxx writes 01,00,FF,77,B3,51,A8,D4,62,39,9C,46,2B,15,8A,CD,EE -> seq_pos steps 0,1,2..15; after EE, asic_unlocked=1, one-cycle unlock_now, seq_pos=0.
- Relock: from unlocked, same sequence ending in 00 instead of EE -> asic_unlocked=0, one-cycle lock_now, seq_pos=1 (resync, since CD is nonzero).
- Mismatch and resync: 01,00,FF,77,42 -> seq_pos=0, asic_unlocked unchanged. Then 55,00 -> seq_pos=1.
- Interleaved traffic: the valid sequence with 7F C0 and DF 03 writes between every BCxx byte, and io_WR held high 5 cycles per write -> still unlocks, exactly one event per write.
- Reset and mode: reset asserted at seq_pos=9 while unlocked -> next cycle all outputs 0. With plus_mode=0, the full sequence -> asic_unlocked stays 0, no pulses.
- No sync without nonzero: immediately after reset (prev_nz=0), 00,FF,77 -> seq_pos stays 0.

Source files
------------

// File: rtl/plus_asic_unlock.sv
// plus_asic_unlock: CPC Plus ASIC unlock-sequence detector snooping BCxx I/O writes
module plus_asic_unlock (
   input  logic        CLK,
   input  logic        reset,
   input  logic        plus_mode,
   input  logic        io_WR,
   input  logic [15:0] A,
   input  logic [7:0]  D,
   output logic        asic_unlocked,
   output logic        unlock_now,
   output logic        lock_now,
   output logic [4:0]  seq_pos
);
   logic       r_old_wr;
   logic       r_prev_nz;
   logic       r_unl;
   logic       r_un;
   logic       r_ln;
   logic [4:0] r_seq;
   logic       w_ev;
   logic       w_sync;
   logic       w_mid;
   logic       w_fin;
   logic       w_ee;
   logic [7:0] w_exp;
   always_comb begin
      case (r_seq[3:0])
         4'd1:    w_exp = 8'hFF;
         4'd2:    w_exp = 8'h77;
         4'd3:    w_exp = 8'hB3;
         4'd4:    w_exp = 8'h51;
         4'd5:    w_exp = 8'hA8;
         4'd6:    w_exp = 8'hD4;
         4'd7:    w_exp = 8'h62;
         4'd8:    w_exp = 8'h39;
         4'd9:    w_exp = 8'h9C;
         4'd10:   w_exp = 8'h46;
         4'd11:   w_exp = 8'h2B;
         4'd12:   w_exp = 8'h15;
         4'd13:   w_exp = 8'h8A;
         4'd14:   w_exp = 8'hCD;
         default: w_exp = 8'h00;
      endcase
   end
   assign w_ev   = ~r_old_wr & io_WR & (A[15:8] == 8'hBC);
   assign w_sync = (D == 8'h00) & r_prev_nz;
   assign w_mid  = (r_seq != 5'd0) & (r_seq != 5'd15);
   assign w_fin  = w_ev & (r_seq == 5'd15);
   assign w_ee   = (D == 8'hEE);
   // resync on "nonzero, 00" wins over the position match in every state
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_old_wr  <= 1'b0;
         r_prev_nz <= 1'b0;
         r_unl     <= 1'b0;
         r_un      <= 1'b0;
         r_ln      <= 1'b0;
         r_seq     <= 5'd0;
      end else begin
         r_old_wr <= io_WR;
         if (!plus_mode) begin
            r_prev_nz <= 1'b0;
            r_unl     <= 1'b0;
            r_un      <= 1'b0;
            r_ln      <= 1'b0;
            r_seq     <= 5'd0;
         end else begin
            r_un <= w_fin & w_ee;
            r_ln <= w_fin & ~w_ee;
            if (w_fin) r_unl <= w_ee;
            if (w_ev) begin
               r_prev_nz <= (D != 8'h00);
               r_seq     <= w_sync ? 5'd1 : (w_mid && D == w_exp) ? r_seq + 5'd1 : 5'd0;
            end
         end
      end
   end
   assign asic_unlocked = r_unl;
   assign unlock_now    = r_un;
   assign lock_now      = r_ln;
   assign seq_pos       = r_seq;
endmodule

// File: tb/tb_plus_asic_unlock.sv
// tb_plus_asic_unlock: table-driven directed bench for the Plus ASIC unlock detector
module tb_plus_asic_unlock;
   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        plus_mode = 1'b1;
   logic        io_WR = 1'b0;
   logic [15:0] A = 16'h0000;
   logic [7:0]  D = 8'h00;
   logic        asic_unlocked;
   logic        unlock_now;
   logic        lock_now;
   logic [4:0]  seq_pos;
   int n_cmp = 0;
   int n_err = 0;
   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      int          hold;
      logic [4:0]  s;
      logic        u;
      logic        un;
      logic        ln;
   } vec_t;
   vec_t q[$];
   logic [7:0] seq_b [0:15] = '{8'h01, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4,
                                8'h62, 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD};

   plus_asic_unlock dut (
      .CLK(CLK), .reset(reset), .plus_mode(plus_mode), .io_WR(io_WR), .A(A), .D(D),
      .asic_unlocked(asic_unlocked), .unlock_now(unlock_now), .lock_now(lock_now),
      .seq_pos(seq_pos)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input int s, input int u, input int un, input int ln);
      chk({nm, " seq_pos"}, int'(seq_pos), s);
      chk({nm, " asic_unlocked"}, int'(asic_unlocked), u);
      chk({nm, " unlock_now"}, int'(unlock_now), un);
      chk({nm, " lock_now"}, int'(lock_now), ln);
   endtask

   task automatic push(input logic [15:0] a, input logic [7:0] d, input int hold,
                       input logic [4:0] s, input logic u, input logic un, input logic ln);
      vec_t v;
      v.a = a; v.d = d; v.hold = hold; v.s = s; v.u = u; v.un = un; v.ln = ln;
      q.push_back(v);
   endtask

   // 16 leading bytes land on positions 0..15; the final byte's outcome is given by the caller
   task automatic add_seq(input logic [7:0] fin, input int hold, input bit il, input logic ub,
                          input logic [4:0] sf, input logic ua, input logic un, input logic ln);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) push(16'hBC5A, seq_b[i], hold, 5'(i), ub, 1'b0, 1'b0);
         else push(16'hBC00, fin, hold, sf, ua, un, ln);
         if (il && i < 16) begin
            push(16'h7F00, 8'hC0, hold, 5'(i), ub, 1'b0, 1'b0);
            push(16'hDF00, 8'h03, hold, 5'(i), ub, 1'b0, 1'b0);
         end
      end
   endtask

   task automatic wr(input vec_t v, input int k);
      @(negedge CLK);
      A = v.a; D = v.d; io_WR = 1'b1;
      @(posedge CLK); #1;
      chk_all($sformatf("v%0d write", k), int'(v.s), int'(v.u), int'(v.un), int'(v.ln));
      repeat (v.hold - 1) @(posedge CLK);
      @(negedge CLK);
      io_WR = 1'b0;
      @(posedge CLK); #1;
      chk_all($sformatf("v%0d after", k), int'(v.s), int'(v.u), 0, 0);
   endtask

   task automatic run_table();
      foreach (q[k]) wr(q[k], n_cmp);
      q.delete();
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #1 chk_all("reset", 0, 0, 0, 0);
      @(negedge CLK) reset = 1'b0;
      add_seq(8'hEE, 1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      run_table();
      push(16'hBC00, 8'h01, 1, 5'd0, 1'b1, 1'b0, 1'b0);
      push(16'hBC00, 8'h00, 1, 5'd1, 1'b1, 1'b0, 1'b0);
      push(16'hBC00, 8'hFF, 1, 5'd2, 1'b1, 1'b0, 1'b0);
      push(16'hBC00, 8'h77, 1, 5'd3, 1'b1, 1'b0, 1'b0);
      push(16'hBC00, 8'h42, 1, 5'd0, 1'b1, 1'b0, 1'b0);
      push(16'hBC00, 8'h55, 1, 5'd0, 1'b1, 1'b0, 1'b0);
      push(16'hBC00, 8'h00, 1, 5'd1, 1'b1, 1'b0, 1'b0);
      run_table();
      add_seq(8'h00, 1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1);
      run_table();
      add_seq(8'hEE, 5, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      run_table();
      push(16'hBC00, 8'h01, 1, 5'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 10; i++) push(16'hBC00, seq_b[i], 1, 5'(i), 1'b1, 1'b0, 1'b0);
      run_table();
      @(negedge CLK) reset = 1'b1;
      @(posedge CLK); #1;
      chk_all("midseq reset", 0, 0, 0, 0);
      @(negedge CLK) reset = 1'b0;
      push(16'hBC00, 8'h00, 1, 5'd0, 1'b0, 1'b0, 1'b0);
      push(16'hBC00, 8'hFF, 1, 5'd0, 1'b0, 1'b0, 1'b0);
      push(16'hBC00, 8'h77, 1, 5'd0, 1'b0, 1'b0, 1'b0);
      run_table();
      @(negedge CLK) plus_mode = 1'b0;
      for (int i = 0; i < 16; i++) push(16'hBC00, seq_b[i], 1, 5'd0, 1'b0, 1'b0, 1'b0);
      push(16'hBC00, 8'hEE, 1, 5'd0, 1'b0, 1'b0, 1'b0);
      run_table();
      @(negedge CLK) plus_mode = 1'b1;
      add_seq(8'hEE, 1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      run_table();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
